// File: rtl/riscv_lsu_pkg.sv
// RISC-V load/store unit shared types: funct3 sizes, FSM states,
// latched request bundle and size-decoding helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } width_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
  } lsu_req_t;

  // Reserved funct3 encodings fall through to word accesses
  function automatic width_t f3_width(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [1:0] lo);
    case (f3_width(f3))
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store replication
// and load extraction with sign/zero extension.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wd_rep,
  output logic [31:0] rd_ext
);

  width_t      w;
  logic        sx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign w        = f3_width(size);
  assign sx       = ~f3_unsigned(size);
  assign byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be     = 4'hf;
    wd_rep = wd;
    rd_ext = rd_word;
    unique case (w)
      SZ_BYTE: begin
        be     = 4'b0001 << addr_lo;
        wd_rep = {4{wd[7:0]}};
        rd_ext = {{24{sx & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wd[15:0]}};
        rd_ext = {{16{sx & half_sel[15]}}, half_sel};
      end
      default: begin
        be     = 4'hf;
        wd_rep = wd;
        rd_ext = rd_word;
      end
    endcase
    if (!we) be = 4'hf;
  end

endmodule

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: IDLE/BUSY/DONE handshake with timeout.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned H/W accesses.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  // Timeout fires in the (MAX_WAIT-1)th BUSY cycle
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 2);

  state_t      state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bad;
  logic        busy, done;
  logic [3:0]  be;
  logic [31:0] wd_rep, rd_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  assign bad = misaligned(core_size_i, core_addr_i[1:0]);
`else
  assign bad = 1'b0;
`endif

  lsu_align u_align (
    .we      (req_q.we),
    .size    (req_q.size),
    .addr_lo (req_q.addr[1:0]),
    .wd      (req_q.wd),
    .rd_word (rdata_q),
    .be      (be),
    .wd_rep  (wd_rep),
    .rd_ext  (rd_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          req_d   = '{we:   core_we_i,
                      size: core_size_i,
                      addr: core_addr_i,
                      wd:   core_wd_i};
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = bad;
          state_d = bad ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready_i) begin
          rdata_d = mem_rd_i;
          state_d = S_DONE;
        end else if (cnt_q == LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_BUSY);
  assign done = (state_q == S_DONE);

  // Gate the request-cycle stall so nothing leaks while in reset
  assign core_stall_o = ~rst_i &
                        (((state_q == S_IDLE) & core_req_i) | busy);

  assign mem_req_o  = busy;
  assign mem_we_o   = busy & req_q.we;
  assign mem_be_o   = busy ? be : 4'h0;
  assign mem_addr_o = busy ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign mem_wd_o   = (busy & req_q.we) ? wd_rep : 32'h0;

  assign core_rd_o = (done & ~req_q.we & ~err_q) ? rd_ext : 32'h0;
  assign err_o     = done & err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed table, reset
// sequences and randomized accesses against a reference model.
module tb_riscv_lsu;

  localparam int MW = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.MAX_WAIT(MW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] word;
    int          delay;
    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural reference: access size in bytes, lane shift arithmetic
  task automatic model(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int delay,
                       output vec_t v);
    int          nb;
    int          sh;
    int          nbusy;
    logic        sgn;
    logic        bad;
    logic [31:0] mask;
    logic [31:0] x;
    nb  = (sz == 3'd0 || sz == 3'd4) ? 1 :
          (sz == 3'd1 || sz == 3'd5) ? 2 : 4;
    sgn = (sz == 3'd0 || sz == 3'd1);
    v.we = we; v.sz = sz; v.a = a; v.wd = wd;
    v.word = word; v.delay = delay;
    v.maddr = a & ~32'd3;
    v.be = 4'hf; v.mwd = 32'h0; v.rd = 32'h0;
    bad = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    bad = (a % nb) != 0;
`endif
    if (bad) begin
      v.err = 1'b1;
      v.cyc = 2;
      return;
    end
    if (delay < MW - 1) begin
      nbusy = delay + 1;
      v.err = 1'b0;
    end else begin
      nbusy = MW - 1;
      v.err = 1'b1;
    end
    v.cyc = nbusy + 2;
    sh = (nb == 4) ? 0 : (int'(a % 4) / nb) * nb * 8;
    if (we) begin
      v.be = (nb == 4) ? 4'hf : 4'(((1 << nb) - 1) << (sh / 8));
      v.mwd = (nb == 1) ? wd[7:0] * 32'h01010101 :
              (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
    end else if (!v.err) begin
      mask = (nb == 4) ? 32'hffffffff : (32'd1 << (nb * 8)) - 1;
      x = (word >> sh) & mask;
      if (sgn && x[nb*8-1]) x = x | ~mask;
      v.rd = x;
    end
  endtask

  task automatic run_access(input vec_t v, input string tag);
    int          cyc;
    int          nreq;
    logic        fin;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] maddr;
    logic        mwe;
    cyc = 0; nreq = 0; fin = 1'b0;
    rd = 'x; err = 'x; be = 'x; mwd = 'x; maddr = 'x; mwe = 'x;
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = v.we; core_size_i = v.sz;
    core_addr_i = v.a; core_wd_i = v.wd;
    mem_ready_i = 1'($urandom); mem_rd_i = $urandom;
    #1;
    check({tag, " stall_req"}, 32'(core_stall_o), 32'd1);
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      cyc++;
      if (mem_req_o) begin
        be = mem_be_o; mwd = mem_wd_o;
        maddr = mem_addr_o; mwe = mem_we_o;
        check({tag, " stall_busy"}, 32'(core_stall_o), 32'd1);
        check({tag, " rd_busy"}, core_rd_o, 32'h0);
        mem_ready_i = (nreq == v.delay);
        mem_rd_i = mem_ready_i ? v.word : $urandom;
        nreq++;
      end else begin
        rd = core_rd_o; err = err_o;
        check({tag, " stall_done"}, 32'(core_stall_o), 32'd0);
        mem_ready_i = 1'($urandom); mem_rd_i = $urandom;
        fin = 1'b1;
        break;
      end
    end
    if (!fin) cyc = -1;
    check({tag, " cycles"}, 32'(cyc), 32'(v.cyc));
    check({tag, " nreq"}, 32'(nreq), 32'(v.cyc - 2));
    check({tag, " rd"}, rd, v.rd);
    check({tag, " err"}, 32'(err), 32'(v.err));
    if (v.cyc > 2) begin
      check({tag, " be"}, 32'(be), 32'(v.be));
      check({tag, " addr"}, maddr, v.maddr);
      check({tag, " we"}, 32'(mwe), 32'(v.we));
      if (v.we) check({tag, " wd"}, mwd, v.mwd);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd"}, core_rd_o, 32'h0);
    check({tag, " stall"}, 32'(core_stall_o), 32'd0);
    check({tag, " err"}, 32'(err_o), 32'd0);
    check({tag, " req"}, 32'(mem_req_o), 32'd0);
    check({tag, " we"}, 32'(mem_we_o), 32'd0);
    check({tag, " be"}, 32'(mem_be_o), 32'd0);
    check({tag, " addr"}, mem_addr_o, 32'h0);
    check({tag, " wd"}, mem_wd_o, 32'h0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                 32'hDEADBEEF, 1'b0, 3, 4'hf, 32'h0, 32'h100};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1,
                 32'hFFFFFF80, 1'b0, 4, 4'hf, 32'h0, 32'h100};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0,
                 32'h00000080, 1'b0, 3, 4'hf, 32'h0, 32'h100};
    vecs[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0,
                 32'h0, 1'b0, 3, 4'b1100, 32'hABCDABCD, 32'h200};
    vecs[4]  = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h55AA55AA, 9,
                 32'h0, 1'b1, 5, 4'hf, 32'h0, 32'h40};
    vecs[5]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2,
                 32'hFFFF8001, 1'b0, 5, 4'hf, 32'h0, 32'h100};
    vecs[6]  = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F00F, 0,
                 32'h0000F00F, 1'b0, 3, 4'hf, 32'h0, 32'h100};
    vecs[7]  = '{1'b1, 3'b000, 32'h001, 32'h000000A5, 32'h0, 1,
                 32'h0, 1'b0, 4, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h7FC, 32'hCAFEF00D, 32'h0, 0,
                 32'h0, 1'b0, 3, 4'hf, 32'hCAFEF00D, 32'h7FC};
    vecs[9]  = '{1'b0, 3'b011, 32'h010, 32'h0, 32'h12345678, 0,
                 32'h12345678, 1'b0, 3, 4'hf, 32'h0, 32'h10};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[10] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0,
                 32'h0, 1'b1, 2, 4'hf, 32'h0, 32'h100};
`else
    vecs[10] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0,
                 32'h11223344, 1'b0, 3, 4'hf, 32'h0, 32'h100};
`endif
    vecs[11] = '{1'b1, 3'b110, 32'h008, 32'h89ABCDEF, 32'h0, 0,
                 32'h0, 1'b0, 3, 4'hf, 32'h89ABCDEF, 32'h8};

    rst_i = 1'b1;
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b000;
    core_addr_i = 32'h3; core_wd_i = 32'hFFFFFFFF;
    mem_rd_i = 32'hFFFFFFFF; mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b0;

    foreach (vecs[i]) run_access(vecs[i], $sformatf("vec%0d", i));

    // Reset in the 2nd BUSY cycle, then a clean 3-cycle access
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010;
    core_addr_i = 32'h300; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    check("midrst busy2 req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1; core_req_i = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk_i); #1;
    rst_i = 1'b0; core_req_i = 1'b0;
    model(1'b0, 3'b010, 32'h304, 32'h0, 32'h0BADF00D, 0, v);
    run_access(v, "postrst");

    for (int n = 0; n < 40; n++) begin
      model(1'($urandom), 3'($urandom), $urandom, $urandom,
            $urandom, int'($urandom_range(0, 4)), v);
      run_access(v, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
